// File: rtl/bbox_pkg.sv
// bbox_pkg: shared constants for the bounding-box controller.
// FSM encodings, CSR word map and STATUS bit positions.
package bbox_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PIXEL  = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_RESULT = 2'd3;

  localparam int SB_BUSY  = 0;
  localparam int SB_DONE  = 1;
  localparam int SB_TMO   = 2;
  localparam int SB_RANGE = 3;
  localparam int SB_BWR   = 4;

  typedef struct packed {
    logic bwr;
    logic range;
    logic tmo;
    logic done;
  } flags_t;

endpackage

// File: rtl/bbox_if.sv
// bbox_if: Avalon-MM CSR slave bundle.
// Fixed read latency 1, zero write wait states.
interface bbox_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/bbox_csr.sv
// bbox_csr: CSR file for bbox_ctrl.
// Command decode, sticky W1C status, result latch, read mux.
module bbox_csr
  import bbox_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  bbox_if.slave       avs,
  input  logic        busy,
  input  logic        set_done,
  input  logic        set_tmo,
  input  logic        clr_flags,
  input  logic        set_range,
  input  logic        set_bwr,
  input  logic [31:0] coords,
  output logic        go,
  output logic        abort,
  output logic        pix_wr,
  output logic        irq
);

  logic        irq_en;
  flags_t      f;
  logic [31:0] result;
  logic [31:0] w1c;
  logic [31:0] status;
  logic [31:0] rd_mux;
  logic        wr_ctrl;

  assign wr_ctrl = avs.write && (avs.address == A_CTRL);
  assign pix_wr  = avs.write && (avs.address == A_PIXEL);
  assign abort   = wr_ctrl & avs.writedata[1];
  assign go      = wr_ctrl & avs.writedata[0]
                 & ~avs.writedata[1];
  assign w1c     = (avs.write && avs.address == A_STATUS)
                 ? avs.writedata : 32'd0;

  assign irq = irq_en & (f.done | f.tmo);

  always_comb begin
    status           = '0;
    status[SB_BUSY]  = busy;
    status[SB_DONE]  = f.done;
    status[SB_TMO]   = f.tmo;
    status[SB_RANGE] = f.range;
    status[SB_BWR]   = f.bwr;
  end

  always_comb begin
    rd_mux = '0;
    unique case (avs.address)
      A_CTRL:   rd_mux = {29'd0, irq_en, 2'd0};
      A_PIXEL:  rd_mux = '0;
      A_STATUS: rd_mux = status;
      A_RESULT: rd_mux = result;
    endcase
  end

  // a new event in the same cycle as its W1C keeps the bit set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en       <= 1'b0;
      f            <= '0;
      result       <= '0;
      avs.readdata <= '0;
    end else begin
      if (wr_ctrl)
        irq_en <= avs.writedata[2];
      f.done  <= ~clr_flags
               & (set_done | (f.done & ~w1c[SB_DONE]));
      f.tmo   <= ~clr_flags
               & (set_tmo | (f.tmo & ~w1c[SB_TMO]));
      f.range <= set_range | (f.range & ~w1c[SB_RANGE]);
      f.bwr   <= set_bwr | (f.bwr & ~w1c[SB_BWR]);
      if (set_done)
        result <= coords;
      if (avs.read)
        avs.readdata <= rd_mux;
    end
  end

endmodule

// File: rtl/bbox_ctrl.sv
// bbox_ctrl: sequences the bounding-box engine for the host.
// Owns the frame-RAM port, run FSM and cycle timeout.
module bbox_ctrl
  import bbox_pkg::*;
#(
  parameter int PIXELS  = 30000,
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 1048576
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  bbox_if.slave             avs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rddata,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic [31:0]       eng_addr,
  output logic [15:0]       eng_rddata,
  input  logic [31:0]       eng_coords,
  output logic              irq
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          in_run;
  logic          go;
  logic          abort;
  logic          pix_wr;
  logic          pix_in;
  logic          pix_ok;
  logic          start_ev;
  logic          done_ev;
  logic          tmo_ev;
  logic          oob_q;
  logic [23:0]   pix_idx;

  assign in_run   = (state == ST_RUN);
  assign pix_idx  = avs.writedata[23:0];
  assign pix_in   = pix_idx < 24'(PIXELS);
  assign pix_ok   = pix_wr & ~in_run & pix_in;
  assign start_ev = go & ~in_run;
  assign done_ev  = in_run & eng_done & ~abort;
  assign tmo_ev   = in_run & ~eng_done & ~abort
                  & (cnt == LAST);

  bbox_csr u_csr (
    .clk       (CLOCK_50),
    .rst_n     (reset_n),
    .avs       (avs),
    .busy      (in_run),
    .set_done  (done_ev),
    .set_tmo   (tmo_ev),
    .clr_flags (start_ev),
    .set_range (pix_wr & ~in_run & ~pix_in),
    .set_bwr   (pix_wr & in_run),
    .coords    (eng_coords),
    .go        (go),
    .abort     (abort),
    .pix_wr    (pix_wr),
    .irq       (irq)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      eng_start <= 1'b0;
      oob_q     <= 1'b0;
    end else begin
      eng_start <= start_ev;
      oob_q     <= eng_addr >= 32'(PIXELS);
      if (abort)
        state <= ST_IDLE;
      else if (start_ev) begin
        state <= ST_RUN;
        cnt   <= '0;
      end else if (done_ev | tmo_ev)
        state <= ST_DONE;
      else if (in_run)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      in_run: ram_addr = eng_addr[ADDR_W-1:0];
      pix_ok: begin
        ram_we    = 1'b1;
        ram_addr  = pix_idx[ADDR_W-1:0];
        ram_wdata = avs.writedata[31:24];
      end
      default: ;
    endcase
  end

  // oob_q lines up with the RAM's one-cycle read return
  assign eng_rddata = (in_run && !oob_q)
                    ? {8'h00, ram_rddata} : 16'h0000;

endmodule

// File: doc/bbox_ctrl.md
Name: bbox_ctrl

Overview:
- Avalon-MM slave controller that sequences the bounding-box engine for the host.
- Owns the single frame-RAM port: host pixel writes are allowed when the engine is idle, and engine reads are allowed while it runs.
- Provides GO/ABORT, status, a cycle timeout, a latched result register and an interrupt.
- Sits between the HPS bridge and the boundingBox engine plus its 8-bit frame RAM.

Parameters:
- PIXELS, 30000, number of valid frame-RAM bytes (100x100 image, 3 planes).
- ADDR_W, 15, frame-RAM address width.
- TIMEOUT, 1048576, maximum RUN cycles before forced abort.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- avs_address  in  2  CSR word select.
- avs_read  in  1  CSR read strobe; fixed read latency 1.
- avs_write  in  1  CSR write strobe; zero wait states.
- avs_writedata  in  32  CSR write data.
- avs_readdata  out  32  CSR read data, registered.
- ram_we  out  1  frame-RAM write enable.
- ram_addr  out  ADDR_W  frame-RAM address.
- ram_wdata  out  8  frame-RAM write data.
- ram_rddata  in  8  frame-RAM read data; 1-cycle latency from ram_addr.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_done  in  1  engine completion, level or pulse.
- eng_addr  in  32  engine read address.
- eng_rddata  out  16  engine read data.
- eng_coords  in  32  {xMin,xMax,yMin,yMax} from the engine.
- irq  out  1  level interrupt.

Behaviour:
- Reset: state IDLE. All outputs are 0. RESULT=0, STATUS=0, irq_en=0, cycle counter=0.
- Register map:
  - 0 CTRL: W bit0 GO, bit1 ABORT, bit2 IRQ_EN (stored). R returns {29'b0, irq_en, 2'b0}.
  - 1 PIXEL: W only. [31:24] value, [23:0] index. R returns 0.
  - 2 STATUS: R bit0 busy, bit1 done, bit2 timeout, bit3 range_err, bit4 busy_wr_err. W1C clears bits 1-4; bit0 is read-only.
  - 3 RESULT: R returns the coordinates latched at the last successful completion.
- Reads: avs_readdata is valid exactly 1 cycle after avs_read. It holds its value otherwise.
- States:
  - IDLE -> RUN on GO.
  - RUN -> DONE on eng_done.
  - RUN -> DONE on counter==TIMEOUT-1, which sets timeout.
  - RUN -> IDLE on ABORT.
  - DONE -> RUN on GO.
  - DONE -> IDLE on ABORT. Status bits persist until cleared by W1C.
- GO (IDLE/DONE): clear done and timeout; assert eng_start for exactly the next cycle; zero the counter; enter RUN. busy=1 throughout RUN.
- GO in RUN is ignored.
- GO and ABORT in the same write: ABORT wins, no start.
- PIXEL write in IDLE/DONE with index<PIXELS: ram_we=1, ram_addr=index[ADDR_W-1:0], ram_wdata=value, driven combinationally in the write cycle.
- PIXEL write with index>=PIXELS: dropped, range_err set.
- PIXEL write in RUN: dropped, busy_wr_err set, RAM untouched.
- RUN RAM mux:
  - ram_we=0, ram_addr=eng_addr[ADDR_W-1:0].
  - eng_rddata={8'h00, ram_rddata}. Read latency 1 is passed through to the engine.
  - If eng_addr>=PIXELS, eng_rddata=0 on the corresponding return cycle.
  - Outside RUN, eng_rddata=0.
- Completion: on eng_done in RUN, RESULT<=eng_coords in the same edge and done<=1.
- eng_done and timeout in the same cycle: done wins, timeout stays 0, RESULT is updated.
- eng_done outside RUN is ignored.
- Timeout: RESULT is unchanged.
- ABORT in RUN: no done, RESULT unchanged. The next GO restarts the engine via eng_start.
- irq = irq_en & (done | timeout), combinational from registered bits.
- Asynchronous reset mid-RUN returns to the reset state immediately. The engine is reset by the same reset_n.

Decomposition:
- Package bbox_pkg:
  - state enum {IDLE, RUN, DONE}.
  - CSR address constants CTRL=0, PIXEL=1, STATUS=2, RESULT=3.
  - STATUS bit-index constants.
- One natural sub-module, bbox_csr: register file, W1C logic and read mux.
- FSM, counter and RAM mux stay in bbox_ctrl.

Test Plan:
- Reset, then read regs 0-3 -> all read 0x00000000; irq=0; eng_start=0.
- PIXEL write 0xFF000123 in IDLE -> ram_we=1, ram_addr=0x123, ram_wdata=0xFF for one cycle.
- PIXEL write with index 30000 -> no ram_we; STATUS=0x8.
- CTRL write 0x5 (GO + IRQ_EN) -> eng_start high one cycle, STATUS.busy=1, eng_addr=0x10 routed to ram_addr.
- Engine returns eng_done with coords 0x0A5A1463 -> RESULT=0x0A5A1463, STATUS=0x2, irq=1. W1C 0x2 -> irq=0.
- GO with an engine that never finishes, TIMEOUT=16 -> after 16 RUN cycles STATUS=0x4 and RESULT unchanged.
- ABORT mid-run -> IDLE, done=0.
- PIXEL write during RUN -> STATUS bit4 set, RAM untouched.
